fg_bbox_overlay: RTL and testbench

//  Consumes the per-pixel foreground flag and display pixel stream from background_substractor.

---
 rtl/fg_bbox_overlay_pkg.sv | 47 ++++
 rtl/fg_bbox_overlay_if.sv | 46 ++++
 rtl/fg_bbox_overlay_accumulator.sv | 53 +++++
 rtl/fg_bbox_overlay.sv | 159 +++++++++++++++
 tb/tb_fg_bbox_overlay.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fg_bbox_overlay_pkg.sv
// -----------------------------------------------------------------------------
// fg_bbox_pkg
// Shared types and constants for the foreground bounding-box overlay:
//   COORD_W        - width of pixel row/column coordinates
//   coord_t        - one pixel coordinate
//   bbox_t         - box extents {xmin, xmax, ymin, ymax}
//   fsm_state_t    - frame FSM states {WAIT_SOF, ACCUM, LATCH}
//   COORD_SENTINEL - "no pixel seen yet" value for the min accumulators
//   BBOX_EMPTY     - accumulator seed: mins at the sentinel, maxes at zero
//   mid()          - centre of two coordinates (wide sum, then halve)
// -----------------------------------------------------------------------------
package fg_bbox_pkg;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t xmin;
        coord_t xmax;
        coord_t ymin;
        coord_t ymax;
    } bbox_t;

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACCUM,
        LATCH
    } fsm_state_t;

    localparam coord_t COORD_SENTINEL = 11'h7FF;

    localparam bbox_t BBOX_EMPTY = '{
        xmin: COORD_SENTINEL,
        xmax: '0,
        ymin: COORD_SENTINEL,
        ymax: '0
    };

    // The sum is taken one bit wider so the halved result never wraps.
    function automatic coord_t mid(input coord_t a, input coord_t b);
        logic [COORD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[COORD_W:1];
    endfunction

endpackage

// File: rtl/fg_bbox_overlay_if.sv
// -----------------------------------------------------------------------------
// fg_bbox_overlay_if
// Video-in / video-out / box-result bundle of fg_bbox_overlay.
//   vid_hpos, vid_vpos   current pixel column / row
//   vid_active_pix       high inside the active video area
//   foregnd_px           foreground flag aligned with vid_data_in
//   vid_data_in          RGB pixel from upstream
//   vid_data_out         RGB pixel with overlay (registered, 1 clock latency)
//   box_xmin..box_ymax   latched box of the previous frame
//   box_pix_count        latched foreground pixel count (saturating)
//   box_valid            latched box met the minimum pixel count
//   frame_done           one-cycle pulse when the box outputs update
// Modports: master = video source / result consumer, slave = the overlay.
// -----------------------------------------------------------------------------
interface fg_bbox_overlay_if
    import fg_bbox_pkg::*;
#(
    parameter int CNT_W = 19
);
    coord_t             vid_hpos;
    coord_t             vid_vpos;
    logic               vid_active_pix;
    logic               foregnd_px;
    logic [23:0]        vid_data_in;
    logic [23:0]        vid_data_out;
    coord_t             box_xmin;
    coord_t             box_xmax;
    coord_t             box_ymin;
    coord_t             box_ymax;
    logic [CNT_W-1:0]   box_pix_count;
    logic               box_valid;
    logic               frame_done;

    modport master (
        output vid_hpos, vid_vpos, vid_active_pix, foregnd_px, vid_data_in,
        input  vid_data_out, box_xmin, box_xmax, box_ymin, box_ymax,
               box_pix_count, box_valid, frame_done
    );

    modport slave (
        input  vid_hpos, vid_vpos, vid_active_pix, foregnd_px, vid_data_in,
        output vid_data_out, box_xmin, box_xmax, box_ymin, box_ymax,
               box_pix_count, box_valid, frame_done
    );

endinterface

// File: rtl/fg_bbox_overlay_accumulator.sv
// -----------------------------------------------------------------------------
// bbox_accumulator
// Running min/max of foreground pixel coordinates and a saturating count.
//   clk, rst  clock, asynchronous active-high reset
//   seed      start of frame: restart the accumulators from this pixel
//   hit       this pixel is foreground and belongs to the current frame
//   hpos/vpos coordinates of this pixel
//   box       running extents (BBOX_EMPTY when nothing has been seen)
//   count     running foreground count, sticks at 2^CNT_W-1
// -----------------------------------------------------------------------------
module bbox_accumulator
    import fg_bbox_pkg::*;
#(
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed,
    input  logic             hit,
    input  coord_t           hpos,
    input  coord_t           vpos,
    output bbox_t            box,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before the clock edge, whatever the order the
    // statements are written in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            box   <= BBOX_EMPTY;
            count <= '0;
        end else if (seed) begin
            // The start-of-frame pixel itself belongs to the new frame.
            if (hit) begin
                box   <= '{xmin: hpos, xmax: hpos, ymin: vpos, ymax: vpos};
                count <= CNT_W'(1);
            end else begin
                box   <= BBOX_EMPTY;
                count <= '0;
            end
        end else if (hit) begin
            if (hpos < box.xmin) box.xmin <= hpos;
            if (hpos > box.xmax) box.xmax <= hpos;
            if (vpos < box.ymin) box.ymin <= vpos;
            if (vpos > box.ymax) box.ymax <= vpos;
            if (count != CNT_MAX) count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fg_bbox_overlay.sv
// -----------------------------------------------------------------------------
// fg_bbox_overlay
// Accumulates the bounding box and count of foreground pixels over a frame,
// latches them at frame end, and draws the latched box onto the video stream.
//   app_clk  pixel clock
//   reset    asynchronous active-high reset (release is expected to be
//            synchronised to app_clk upstream)
//   bus      fg_bbox_overlay_if.slave: video in, overlaid video out and the
//            latched box results
// Parameters: H_RES_PIX, V_RES_PIX frame size; MIN_PIXELS count needed for a
// valid box; CNT_W counter width; BOX_COLOR drawn colour.
// Build option: define FG_BBOX_CROSSHAIR_EN to also draw a crosshair through
// the box centre; without it only the border is drawn.
// -----------------------------------------------------------------------------
module fg_bbox_overlay
    import fg_bbox_pkg::*;
#(
    parameter int          H_RES_PIX  = 640,
    parameter int          V_RES_PIX  = 480,
    parameter int          MIN_PIXELS = 64,
    parameter int          CNT_W      = 19,
    parameter logic [23:0] BOX_COLOR  = 24'hFF0000
) (
    input  logic               app_clk,
    input  logic               reset,
    fg_bbox_overlay_if.slave   bus
);

    localparam coord_t      H_END   = coord_t'(H_RES_PIX);
    localparam coord_t      V_END   = coord_t'(V_RES_PIX);
    localparam logic [31:0] MIN_CNT = 32'(MIN_PIXELS);

    fsm_state_t       state;
    bbox_t            acc_box;
    bbox_t            box_q;
    logic [CNT_W-1:0] acc_count;
    logic [CNT_W-1:0] count_q;
    logic             box_valid_q;
    logic             frame_done_q;
    logic [23:0]      pix_d;
    logic [23:0]      pix_q;

    logic sof;
    logic in_area;
    logic acc_seed;
    logic acc_hit;

    // ------------------------------------------------------------------
    // Accumulation control
    // ------------------------------------------------------------------
    assign sof     = bus.vid_active_pix && (bus.vid_hpos == '0) && (bus.vid_vpos == '0);
    assign in_area = bus.vid_active_pix && (bus.vid_hpos < H_END) && (bus.vid_vpos < V_END);

    // Pixels are only collected between a seen start of frame and frame end,
    // so a partial frame after reset never reaches the latch.
    assign acc_seed = (state == WAIT_SOF) && sof;
    assign acc_hit  = in_area && bus.foregnd_px && (acc_seed || (state == ACCUM));

    bbox_accumulator #(
        .CNT_W (CNT_W)
    ) u_acc (
        .clk   (app_clk),
        .rst   (reset),
        .seed  (acc_seed),
        .hit   (acc_hit),
        .hpos  (bus.vid_hpos),
        .vpos  (bus.vid_vpos),
        .box   (acc_box),
        .count (acc_count)
    );

    // ------------------------------------------------------------------
    // Frame FSM and result latch
    // ------------------------------------------------------------------
    // NOTE: every register here, result latch included, is cleared by reset so
    // the outputs read zero and nothing is drawn until a full frame latches.
    always_ff @(posedge app_clk or posedge reset) begin
        if (reset) begin
            state        <= WAIT_SOF;
            box_q        <= '0;
            count_q      <= '0;
            box_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                WAIT_SOF: if (sof) state <= ACCUM;
                // First line past the active area: the frame is complete and
                // we are in vertical blanking, so the box swap is never seen.
                ACCUM:    if (bus.vid_vpos == V_END) state <= LATCH;
                LATCH: begin
                    box_q        <= acc_box;
                    count_q      <= acc_count;
                    box_valid_q  <= (32'(acc_count) >= MIN_CNT);
                    frame_done_q <= 1'b1;
                    state        <= WAIT_SOF;
                end
                default:  state <= WAIT_SOF;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Overlay
    // ------------------------------------------------------------------
    logic in_x;
    logic in_y;
    logic on_border;
    logic on_cross;

    assign in_x = (bus.vid_hpos >= box_q.xmin) && (bus.vid_hpos <= box_q.xmax);
    assign in_y = (bus.vid_vpos >= box_q.ymin) && (bus.vid_vpos <= box_q.ymax);

    assign on_border = (((bus.vid_hpos == box_q.xmin) || (bus.vid_hpos == box_q.xmax)) && in_y)
                    || (((bus.vid_vpos == box_q.ymin) || (bus.vid_vpos == box_q.ymax)) && in_x);

`ifdef FG_BBOX_CROSSHAIR_EN
    coord_t cx;
    coord_t cy;

    assign cx       = mid(box_q.xmin, box_q.xmax);
    assign cy       = mid(box_q.ymin, box_q.ymax);
    assign on_cross = in_x && in_y && ((bus.vid_hpos == cx) || (bus.vid_vpos == cy));
`else
    assign on_cross = 1'b0;
`endif

    // NOTE: pix_d gets a default before any condition, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        pix_d = bus.vid_data_in;
        if (!bus.vid_active_pix) begin
            pix_d = '0;
        end else if (box_valid_q && (on_border || on_cross)) begin
            pix_d = BOX_COLOR;
        end
    end

    always_ff @(posedge app_clk or posedge reset) begin
        if (reset) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.vid_data_out  = pix_q;
    assign bus.box_xmin      = box_q.xmin;
    assign bus.box_xmax      = box_q.xmax;
    assign bus.box_ymin      = box_q.ymin;
    assign bus.box_ymax      = box_q.ymax;
    assign bus.box_pix_count = count_q;
    assign bus.box_valid     = box_valid_q;
    assign bus.frame_done    = frame_done_q;

endmodule

// File: tb/tb_fg_bbox_overlay.sv
// -----------------------------------------------------------------------------
// tb_fg_bbox_overlay
// Drives one pixel stream into three overlay instances:
//   u_a  MIN_PIXELS=1,  CNT_W=19
//   u_b  MIN_PIXELS=64, CNT_W=19
//   u_c  MIN_PIXELS=1,  CNT_W=8
// Expected video for each instance is queued as each pixel is driven and
// compared one clock later; box results are checked at every frame end.
// Crosshair expectations follow FG_BBOX_CROSSHAIR_EN.
// -----------------------------------------------------------------------------
module tb_fg_bbox_overlay;
    import fg_bbox_pkg::*;

    localparam int          V_RES = 480;
    localparam logic [23:0] BOX   = 24'hFF0000;

    logic        app_clk = 1'b0;
    logic        reset   = 1'b0;
    coord_t      hpos    = '0;
    coord_t      vpos    = '0;
    logic        act     = 1'b0;
    logic        fg      = 1'b0;
    logic [23:0] din     = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #20 app_clk = ~app_clk;

    fg_bbox_overlay_if #(.CNT_W(19)) if_a ();
    fg_bbox_overlay_if #(.CNT_W(19)) if_b ();
    fg_bbox_overlay_if #(.CNT_W(8))  if_c ();

    assign if_a.vid_hpos = hpos;       assign if_b.vid_hpos = hpos;       assign if_c.vid_hpos = hpos;
    assign if_a.vid_vpos = vpos;       assign if_b.vid_vpos = vpos;       assign if_c.vid_vpos = vpos;
    assign if_a.vid_active_pix = act;  assign if_b.vid_active_pix = act;  assign if_c.vid_active_pix = act;
    assign if_a.foregnd_px = fg;       assign if_b.foregnd_px = fg;       assign if_c.foregnd_px = fg;
    assign if_a.vid_data_in = din;     assign if_b.vid_data_in = din;     assign if_c.vid_data_in = din;

    fg_bbox_overlay #(.MIN_PIXELS(1), .CNT_W(19)) u_a (.app_clk(app_clk), .reset(reset), .bus(if_a.slave));
    fg_bbox_overlay #(.MIN_PIXELS(64), .CNT_W(19)) u_b (.app_clk(app_clk), .reset(reset), .bus(if_b.slave));
    fg_bbox_overlay #(.MIN_PIXELS(1), .CNT_W(8)) u_c (.app_clk(app_clk), .reset(reset), .bus(if_c.slave));

    // Box currently shown by each instance, as the bench expects it.
    bbox_t mb = '0;
    logic  va = 1'b0;
    logic  vb = 1'b0;
    logic  vc = 1'b0;

    typedef struct packed {
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] c;
        coord_t      h;
        coord_t      v;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model_px(input bbox_t b, input logic v, input int h, input int y,
                                             input logic a, input logic [23:0] d);
        int   x0, x1, y0, y1;
        logic ix, iy, edge_hit, cross_hit;
        x0 = int'(b.xmin); x1 = int'(b.xmax); y0 = int'(b.ymin); y1 = int'(b.ymax);
        if (!a) return 24'h0;
        ix = (h >= x0) && (h <= x1);
        iy = (y >= y0) && (y <= y1);
        edge_hit  = ((h == x0 || h == x1) && iy) || ((y == y0 || y == y1) && ix);
        cross_hit = 1'b0;
`ifdef FG_BBOX_CROSSHAIR_EN
        cross_hit = ix && iy && (h == (x0 + x1) / 2 || y == (y0 + y1) / 2);
`endif
        if (v && (edge_hit || cross_hit)) return BOX;
        return d;
    endfunction

    // Drive one pixel and queue what each instance must emit for it.
    task automatic pix(input int h, input int v, input logic a, input logic f);
        exp_t e;
        @(negedge app_clk);
        hpos = coord_t'(h);
        vpos = coord_t'(v);
        act  = a;
        fg   = f;
        din  = 24'($urandom);
        e.a = model_px(mb, va, h, v, a, din);
        e.b = model_px(mb, vb, h, v, a, din);
        e.c = model_px(mb, vc, h, v, a, din);
        e.h = coord_t'(h);
        e.v = coord_t'(v);
        sbq.push_back(e);
    endtask

    task automatic sof(input logic f);
        pix(0, 0, 1'b1, f);
    endtask

    task automatic end_frame(input int n, input int x0, input int x1, input int y0, input int y1);
        bbox_t eb;
        logic  got;
        int    nc;
        eb = '{xmin: coord_t'(x0), xmax: coord_t'(x1), ymin: coord_t'(y0), ymax: coord_t'(y1)};
        nc = (n > 255) ? 255 : n;
        pix(0, V_RES, 1'b0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            pix(0, V_RES + 1, 1'b0, 1'b0);
            @(posedge app_clk); #1;
            if (if_a.frame_done) got = 1'b1;
        end
        chk("frame_done_a", 32'(got), 32'd1);
        chk("frame_done_b", 32'(if_b.frame_done), 32'd1);
        chk("frame_done_c", 32'(if_c.frame_done), 32'd1);
        chk("box_xmin_a", 32'(if_a.box_xmin), 32'(eb.xmin));
        chk("box_xmax_a", 32'(if_a.box_xmax), 32'(eb.xmax));
        chk("box_ymin_a", 32'(if_a.box_ymin), 32'(eb.ymin));
        chk("box_ymax_a", 32'(if_a.box_ymax), 32'(eb.ymax));
        chk("count_a", 32'(if_a.box_pix_count), 32'(n));
        chk("valid_a", 32'(if_a.box_valid), 32'(n >= 1));
        chk("valid_b", 32'(if_b.box_valid), 32'(n >= 64));
        chk("count_b", 32'(if_b.box_pix_count), 32'(n));
        chk("count_c", 32'(if_c.box_pix_count), 32'(nc));
        chk("valid_c", 32'(if_c.box_valid), 32'(n >= 1));
        chk("box_xmax_c", 32'(if_c.box_xmax), 32'(eb.xmax));
        chk("box_ymin_c", 32'(if_c.box_ymin), 32'(eb.ymin));
        pix(0, V_RES + 1, 1'b0, 1'b0);
        @(posedge app_clk); #1;
        chk("frame_done_pulse", 32'(if_a.frame_done), 32'd0);
        mb = eb;
        va = (n >= 1);
        vb = (n >= 64);
        vc = (n >= 1);
    endtask

    task automatic no_frame();
        pix(0, V_RES, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            pix(0, V_RES + 1, 1'b0, 1'b0);
            @(posedge app_clk); #1;
            chk("no_frame_done", 32'(if_a.frame_done), 32'd0);
        end
    endtask

    // Output monitor: one queued expectation per driven pixel.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge app_clk); #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk($sformatf("vid_out_a(%0d,%0d)", e.h, e.v), 32'(if_a.vid_data_out), 32'(e.a));
                chk($sformatf("vid_out_b(%0d,%0d)", e.h, e.v), 32'(if_b.vid_data_out), 32'(e.b));
                chk($sformatf("vid_out_c(%0d,%0d)", e.h, e.v), 32'(if_c.vid_data_out), 32'(e.c));
            end
        end
    end

    initial begin : watchdog
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset state
        #5 reset = 1'b1;
        #10;
        chk("rst_vid_out", 32'(if_a.vid_data_out), 32'd0);
        chk("rst_xmin", 32'(if_a.box_xmin), 32'd0);
        chk("rst_xmax", 32'(if_a.box_xmax), 32'd0);
        chk("rst_ymin", 32'(if_a.box_ymin), 32'd0);
        chk("rst_ymax", 32'(if_a.box_ymax), 32'd0);
        chk("rst_count", 32'(if_a.box_pix_count), 32'd0);
        chk("rst_valid", 32'(if_a.box_valid), 32'd0);
        chk("rst_frame_done", 32'(if_a.frame_done), 32'd0);
        @(negedge app_clk);
        reset = 1'b0;

        // Single foreground pixel
        sof(1'b0);
        pix(50, 10, 1'b1, 1'b0);
        pix(100, 50, 1'b1, 1'b1);
        pix(101, 50, 1'b1, 1'b0);
        end_frame(1, 100, 100, 50, 50);

        // Rectangle, while the single-pixel box is drawn
        sof(1'b0);
        pix(100, 50, 1'b1, 1'b0);
        pix(101, 50, 1'b1, 1'b0);
        pix(100, 49, 1'b1, 1'b0);
        pix(5, 5, 1'b0, 1'b0);
        for (int y = 100; y < 150; y++)
            for (int x = 200; x < 300; x++)
                pix(x, y, 1'b1, 1'b1);
        end_frame(5000, 200, 299, 100, 149);

        // Rectangle box drawn; ten pixels accumulated (below MIN_PIXELS=64)
        sof(1'b0);
        pix(200, 120, 1'b1, 1'b0);
        pix(250, 100, 1'b1, 1'b0);
        pix(250, 120, 1'b1, 1'b0);
        pix(299, 149, 1'b1, 1'b0);
        pix(300, 120, 1'b1, 1'b0);
        pix(250, 150, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) pix(10 + i, 20, 1'b1, 1'b1);
        end_frame(10, 10, 19, 20, 20);

        // Small box drawn only where valid; foreground on the SOF pixel
        sof(1'b1);
        pix(10, 20, 1'b1, 1'b0);
        pix(15, 20, 1'b1, 1'b0);
        pix(15, 21, 1'b1, 1'b0);
        end_frame(1, 0, 0, 0, 0);

        // Empty frame: sentinel box, never valid
        sof(1'b0);
        pix(1, 0, 1'b1, 1'b0);
        end_frame(0, 11'h7FF, 0, 11'h7FF, 0);

        // Reset mid-frame at line 200
        sof(1'b0);
        pix(5, 5, 1'b1, 1'b1);
        pix(7, 100, 1'b1, 1'b1);
        pix(3, 200, 1'b1, 1'b1);
        @(posedge app_clk); #2;
        reset = 1'b1;
        #1;
        chk("midrst_vid_out", 32'(if_a.vid_data_out), 32'd0);
        chk("midrst_valid", 32'(if_a.box_valid), 32'd0);
        chk("midrst_count", 32'(if_a.box_pix_count), 32'd0);
        chk("midrst_xmin", 32'(if_a.box_xmin), 32'd0);
        chk("midrst_frame_done", 32'(if_a.frame_done), 32'd0);
        mb = '0; va = 1'b0; vb = 1'b0; vc = 1'b0;
        @(negedge app_clk);
        reset = 1'b0;
        pix(300, 300, 1'b1, 1'b1);
        pix(301, 300, 1'b1, 1'b0);
        no_frame();
        sof(1'b0);
        pix(400, 310, 1'b1, 1'b1);
        pix(410, 300, 1'b1, 1'b1);
        end_frame(2, 400, 410, 300, 310);

        // Whole-frame extents, count saturation on the 8-bit instance
        sof(1'b1);
        pix(400, 305, 1'b1, 1'b0);
        pix(405, 305, 1'b1, 1'b0);
        pix(639, 0, 1'b1, 1'b1);
        for (int i = 0; i < 296; i++) pix(100 + i, 240, 1'b1, 1'b1);
        pix(0, 479, 1'b1, 1'b1);
        pix(639, 479, 1'b1, 1'b1);
        end_frame(300, 0, 639, 0, 479);

        // Box (100,199,40,59), then crosshair / border probes
        sof(1'b0);
        pix(100, 40, 1'b1, 1'b1);
        pix(199, 59, 1'b1, 1'b1);
        end_frame(2, 100, 199, 40, 59);
        sof(1'b0);
        pix(149, 50, 1'b1, 1'b0);
        pix(120, 49, 1'b1, 1'b0);
        pix(100, 45, 1'b1, 1'b0);
        pix(150, 45, 1'b1, 1'b0);
        pix(120, 60, 1'b1, 1'b0);
        pix(149, 60, 1'b1, 1'b0);
        end_frame(0, 11'h7FF, 0, 11'h7FF, 0);

        @(posedge app_clk); #2;
        chk("queue_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
